tt_ovi_store_rx: RTL and testbench

TT_OVI_STORE_RX -- requirements
Module: tt_ovi_store_rx

---
 rtl/tt_ovi_store_rx_if.sv | 38 +++
 rtl/tt_ovi_store_rx.sv | 120 ++++++++++++
 tb/tb_tt_ovi_store_rx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_ovi_store_rx_if.sv
// Store-receive bus: memop control from the vector unit, store beats in,
// credits and memop completion out, and the memory write request channel.
interface tt_ovi_store_rx_if #(
    parameter int ADDR_W = 40
);
    logic              memop_sync_start;
    logic [ADDR_W-1:0] memop_base_addr;
    logic [5:0]        memop_beats;
    logic              store_valid;
    logic [511:0]      store_data;
    logic              store_credit;
    logic              memop_sync_end;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [511:0]      mem_req_data;
    logic              mem_req_last;
    logic              protocol_err;
    logic              overflow_err;

    // Handshake: a memory request transfers on any rising edge where
    // mem_req_valid && mem_req_ready; valid never depends on ready, and
    // addr/data/last hold steady while valid is high and ready is low.
    // store_valid has no ready: flow control is by store_credit pulses.
    modport master (
        output memop_sync_start, memop_base_addr, memop_beats,
        output store_valid, store_data, mem_req_ready,
        input  store_credit, memop_sync_end, mem_req_valid, mem_req_addr,
        input  mem_req_data, mem_req_last, protocol_err, overflow_err
    );

    modport slave (
        input  memop_sync_start, memop_base_addr, memop_beats,
        input  store_valid, store_data, mem_req_ready,
        output store_credit, memop_sync_end, mem_req_valid, mem_req_addr,
        output mem_req_data, mem_req_last, protocol_err, overflow_err
    );
endinterface

// File: rtl/tt_ovi_store_rx.sv
// Store-data receiver: buffers 512-bit store beats in a credit-managed FIFO
// and turns them into sequential memory write requests for one memop.
module tt_ovi_store_rx #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 40
) (
    input  logic                clk,
    input  logic                reset,
    tt_ovi_store_rx_if.slave    bus,
    output logic [1:0]          dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        END    = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [5:0]        push_rem;
    logic [5:0]        pop_rem;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              credit_q;
    logic              sync_end_q;
    logic              protocol_err_q;
    logic              overflow_err_q;
    logic [511:0]      fifo_mem [DEPTH];

    logic full;
    logic empty;
    logic pop;
    logic beat_ok;
    logic push;
    logic proto_drop;
    logic start_bad;
    logic ovf_drop;

    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = !empty && bus.mem_req_ready;

    // A beat is only legal inside an open memop that still expects data.
    assign beat_ok    = (state == ACTIVE) && (push_rem != 6'd0);
    assign push       = bus.store_valid && beat_ok && (!full || pop);
    assign proto_drop = bus.store_valid && !beat_ok;
    assign start_bad  = bus.memop_sync_start && (state != IDLE);
    assign ovf_drop   = bus.store_valid && beat_ok && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= bus.store_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            addr           <= '0;
            push_rem       <= '0;
            pop_rem        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            credit_q       <= 1'b0;
            sync_end_q     <= 1'b0;
            protocol_err_q <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            credit_q   <= pop;
            sync_end_q <= 1'b0;
            if (proto_drop || start_bad) protocol_err_q <= 1'b1;
            if (ovf_drop)                overflow_err_q <= 1'b1;
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                push_rem <= push_rem - 6'd1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                pop_rem <= pop_rem - 6'd1;
                addr    <= addr + ADDR_W'(64);
            end
            case (state)
                IDLE: begin
                    if (bus.memop_sync_start) begin
                        addr     <= bus.memop_base_addr;
                        push_rem <= bus.memop_beats;
                        pop_rem  <= bus.memop_beats;
                        if (bus.memop_beats == 6'd0) begin
                            state      <= END;
                            sync_end_q <= 1'b1;
                        end else begin
                            state <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (pop && (pop_rem == 6'd1)) begin
                        state      <= END;
                        sync_end_q <= 1'b1;
                    end
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_valid  = !empty;
    assign bus.mem_req_data   = fifo_mem[rd_ptr[AW-1:0]];
    assign bus.mem_req_addr   = addr;
    assign bus.mem_req_last   = !empty && (pop_rem == 6'd1);
    assign bus.store_credit   = credit_q;
    assign bus.memop_sync_end = sync_end_q;
    assign bus.protocol_err   = protocol_err_q;
    assign bus.overflow_err   = overflow_err_q;
    assign dbg_state          = state;
endmodule

// File: tb/tb_tt_ovi_store_rx.sv
// Directed bench for tt_ovi_store_rx: expected memory requests are queued as
// beats are sent and a negedge monitor compares every request handshake.
module tb_tt_ovi_store_rx;
  localparam int ADDR_W = 40;
  localparam int DEPTH  = 4;
  localparam int W      = ADDR_W + 1 + 512;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  tt_ovi_store_rx_if #(.ADDR_W(ADDR_W)) bus ();

  tt_ovi_store_rx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int credit_cnt = 0;
  int end_cnt = 0;
  bit zero_beat = 1'b0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [511:0] beat(input int id);
    logic [31:0] w;
    w = 32'hB0A0_0000 + 32'(id);
    return {16{w}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (!reset) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        got = {bus.mem_req_addr, bus.mem_req_last, bus.mem_req_data};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mem_req_unexpected addr=%h last=%0b", bus.mem_req_addr, bus.mem_req_last);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL mem_req actual addr=%h last=%0b data=%h expected addr=%h last=%0b data=%h",
                     got[W-1 -: ADDR_W], got[512], got[511:0], exp[W-1 -: ADDR_W], exp[512], exp[511:0]);
          end
        end
        if (bus.mem_req_last) last_pop_cyc = cyc;
      end
      if (bus.store_credit) credit_cnt++;
      if (bus.memop_sync_end) begin
        end_cnt++;
        if (!zero_beat) check("sync_end_after_last_pop", 64'(cyc - last_pop_cyc), 64'd1);
      end
    end
  end

  // driver tasks (called at posedge+1)
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [ADDR_W-1:0] base, input logic [5:0] beats);
    bus.memop_sync_start = 1'b1;
    bus.memop_base_addr  = base;
    bus.memop_beats      = beats;
    @(posedge clk); #1;
    bus.memop_sync_start = 1'b0;
  endtask

  task automatic send_beat(input int id, input logic [ADDR_W-1:0] a, input logic lst);
    exp_q.push_back({a, lst, beat(id)});
    bus.store_valid = 1'b1;
    bus.store_data  = beat(id);
    @(posedge clk); #1;
    bus.store_valid = 1'b0;
  endtask

  task automatic send_drop(input int id);
    bus.store_valid = 1'b1;
    bus.store_data  = beat(id);
    @(posedge clk); #1;
    bus.store_valid = 1'b0;
  endtask

  task automatic wait_end(input int target);
    for (int i = 0; i < 200; i++) begin
      if (end_cnt >= target) break;
      @(posedge clk); #1;
    end
    check("sync_end_seen", 64'(end_cnt), 64'(target));
  endtask

  task automatic check_quiet_outputs();
    check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_mem_req_last", 64'(bus.mem_req_last), 64'd0);
    check("rst_store_credit", 64'(bus.store_credit), 64'd0);
    check("rst_sync_end", 64'(bus.memop_sync_end), 64'd0);
    check("rst_protocol_err", 64'(bus.protocol_err), 64'd0);
    check("rst_overflow_err", 64'(bus.overflow_err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
  endtask

  task automatic do_reset();
    bus.memop_sync_start = 1'b0;
    bus.store_valid      = 1'b0;
    reset = 1'b1;
    #1;
    check_quiet_outputs();
    repeat (3) @(posedge clk);
    exp_q.delete();
    #1;
    reset = 1'b0;
    idle(1);
  endtask

  initial begin
    int c0;
    int e0;
    reset                = 1'b0;
    bus.memop_sync_start = 1'b0;
    bus.memop_base_addr  = '0;
    bus.memop_beats      = '0;
    bus.store_valid      = 1'b0;
    bus.store_data       = '0;
    bus.mem_req_ready    = 1'b0;
    #2;
    do_reset();

    // two-beat memop, memory always ready
    bus.mem_req_ready = 1'b1;
    c0 = credit_cnt; e0 = end_cnt;
    start(40'h1000, 6'd2);
    send_beat(1, 40'h1000, 1'b0);
    send_beat(2, 40'h1040, 1'b1);
    wait_end(e0 + 1);
    idle(2);
    check("s1_credits", 64'(credit_cnt - c0), 64'd2);

    // six beats, memory stalls while the FIFO fills
    bus.mem_req_ready = 1'b0;
    c0 = credit_cnt; e0 = end_cnt;
    start(40'h2000, 6'd6);
    for (int i = 0; i < 4; i++) send_beat(10 + i, 40'h2000 + 40'(64 * i), 1'b0);
    idle(2);
    check("s2_overflow_while_full", 64'(bus.overflow_err), 64'd0);
    check("s2_no_credit_stalled", 64'(credit_cnt - c0), 64'd0);
    check("s2_req_valid", 64'(bus.mem_req_valid), 64'd1);
    bus.mem_req_ready = 1'b1;
    send_beat(14, 40'h2100, 1'b0);
    send_beat(15, 40'h2140, 1'b1);
    wait_end(e0 + 1);
    idle(2);
    check("s2_credits", 64'(credit_cnt - c0), 64'd6);
    check("s2_overflow_err", 64'(bus.overflow_err), 64'd0);

    // full FIFO: push+pop together, then push without pop
    bus.mem_req_ready = 1'b0;
    e0 = end_cnt;
    start(40'h3000, 6'd6);
    for (int i = 0; i < 4; i++) send_beat(20 + i, 40'h3000 + 40'(64 * i), 1'b0);
    bus.mem_req_ready = 1'b1;
    send_beat(24, 40'h3100, 1'b0);
    bus.mem_req_ready = 1'b0;
    check("s3_overflow_simul", 64'(bus.overflow_err), 64'd0);
    send_drop(99);
    check("s3_overflow_set", 64'(bus.overflow_err), 64'd1);
    bus.mem_req_ready = 1'b1;
    idle(6);
    check("s3_drained", 64'(bus.mem_req_valid), 64'd0);
    send_beat(25, 40'h3140, 1'b1);
    wait_end(e0 + 1);
    idle(2);
    check("s3_protocol_err", 64'(bus.protocol_err), 64'd0);

    // zero-beat memop and a stray beat in IDLE
    do_reset();
    e0 = end_cnt;
    zero_beat = 1'b1;
    start(40'h5000, 6'd0);
    check("s4_sync_end_next", 64'(bus.memop_sync_end), 64'd1);
    check("s4_no_req_valid", 64'(bus.mem_req_valid), 64'd0);
    idle(2);
    check("s4_one_end", 64'(end_cnt - e0), 64'd1);
    zero_beat = 1'b0;
    check("s4_no_err_yet", 64'(bus.protocol_err), 64'd0);
    send_drop(77);
    check("s4_protocol_err", 64'(bus.protocol_err), 64'd1);

    // reset with three entries queued
    do_reset();
    bus.mem_req_ready = 1'b0;
    start(40'h6000, 6'd6);
    for (int i = 0; i < 3; i++) send_beat(30 + i, 40'h6000 + 40'(64 * i), 1'b0);
    c0 = credit_cnt;
    bus.mem_req_ready = 1'b1;
    do_reset();
    idle(3);
    check("s5_no_flush_credit", 64'(credit_cnt - c0), 64'd0);
    e0 = end_cnt;
    start(40'h7000, 6'd1);
    send_beat(40, 40'h7000, 1'b1);
    wait_end(e0 + 1);
    idle(2);
    check("s5_fresh_credit", 64'(credit_cnt - c0), 64'd1);

    // address wrap at the top of the space
    e0 = end_cnt;
    start(40'hFF_FFFF_FFC0, 6'd2);
    send_beat(50, 40'hFF_FFFF_FFC0, 1'b0);
    send_beat(51, 40'h0, 1'b1);
    wait_end(e0 + 1);
    idle(2);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
